mem_arbiter16: RTL and testbench

Single-port memory arbiter for the cpu16 core. It shares one synchronous single-port 16-bit block RAM between the instruction-fetch port and the data read/write port. Arbitration is fixed-priority with data first, backed by a one-entry data holding slot. An optional anti-starvation counter guarantees fetch progress. It sits between cpu16 and the RAM primitive and produces the `*_rdy` strobes the core samples.

---
 rtl/mem_arbiter16.sv | 84 ++++++++
 tb/tb_mem_arbiter16.sv | 138 +++++++++++++
 2 files changed

// File: rtl/mem_arbiter16.sv
// mem_arbiter16: shares one single-port 16-bit RAM between fetch and data ports, data-first with a one-entry holding slot.
// Optional anti-starvation for fetch is compiled in with `define MEM_ARBITER16_FAIRNESS_EN.
module mem_arbiter16 #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] ins_rd_addr,
    input  logic        ins_rd_req,
    output logic [15:0] ins_rd_data,
    output logic        ins_rd_rdy,
    input  logic [15:0] dat_rw_addr,
    input  logic [15:0] dat_wr_data,
    input  logic        dat_rd_req,
    input  logic        dat_wr_req,
    output logic [15:0] dat_rd_data,
    output logic        dat_rd_rdy,
    output logic        dat_wr_rdy,
    output logic        err,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wr_data,
    output logic        mem_rd_en,
    output logic        mem_wr_en,
    input  logic [15:0] mem_rd_data
);
`ifdef MEM_ARBITER16_FAIRNESS_EN
    localparam logic FAIR = 1'b1;
`else
    localparam logic FAIR = 1'b0;
`endif
    typedef enum logic [1:0] {NONE, INS, DRD, DWR} tag_t;
    tag_t        tag_q, tag_d;
    logic        slot_v_q, slot_v_d, slot_wr_q, slot_wr_d, err_q, err_d;
    logic [15:0] slot_addr_q, slot_addr_d, slot_wdata_q, slot_wdata_d;
    logic [3:0]  starve_q, starve_d;
    logic        new_req, cand_v, cand_wr, force_ins, grant_ins, grant_dat, overflow, load;
    logic [15:0] cand_addr, cand_wdata;
    always_comb begin
        new_req = dat_rd_req | dat_wr_req;
        cand_v = slot_v_q | new_req;
        cand_wr = slot_v_q ? slot_wr_q : dat_wr_req;
        cand_addr = slot_v_q ? slot_addr_q : dat_rw_addr;
        cand_wdata = slot_v_q ? slot_wdata_q : dat_wr_data;
        force_ins = FAIR && ins_rd_req && starve_q == 4'(STARVE_LIMIT);
        grant_ins = !reset && ins_rd_req && (!cand_v || force_ins);
        grant_dat = !reset && cand_v && !grant_ins;
        // A full slot that is not issuing cannot take the new request; it is lost.
        overflow = new_req && slot_v_q && !grant_dat;
        load = new_req && !(grant_dat && !slot_v_q) && !overflow;
        slot_v_d = load || (slot_v_q && !grant_dat);
        slot_wr_d = load ? dat_wr_req : slot_wr_q;
        slot_addr_d = load ? dat_rw_addr : slot_addr_q;
        slot_wdata_d = load ? dat_wr_data : slot_wdata_q;
        err_d = err_q || overflow || (dat_rd_req && dat_wr_req);
        starve_d = (!FAIR || !ins_rd_req || grant_ins) ? 4'd0 : starve_q + 4'd1;
        tag_d = grant_ins ? INS : !grant_dat ? NONE : cand_wr ? DWR : DRD;
        mem_rd_en = grant_ins || (grant_dat && !cand_wr);
        mem_wr_en = grant_dat && cand_wr;
        mem_addr = grant_ins ? ins_rd_addr : grant_dat ? cand_addr : 16'h0;
        mem_wr_data = mem_wr_en ? cand_wdata : 16'h0;
        ins_rd_rdy = !reset && tag_q == INS;
        dat_rd_rdy = !reset && tag_q == DRD;
        dat_wr_rdy = !reset && tag_q == DWR;
        ins_rd_data = mem_rd_data;
        dat_rd_data = mem_rd_data;
        err = err_q;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            tag_q <= NONE;
            slot_v_q <= 1'b0;
            starve_q <= 4'd0;
            err_q <= 1'b0;
        end else begin
            tag_q <= tag_d;
            slot_v_q <= slot_v_d;
            starve_q <= starve_d;
            err_q <= err_d;
        end
        slot_wr_q <= slot_wr_d;
        slot_addr_q <= slot_addr_d;
        slot_wdata_q <= slot_wdata_d;
    end
endmodule

// File: tb/tb_mem_arbiter16.sv
// tb_mem_arbiter16: directed and random stimulus against a queue-based reference model of the arbiter.
module tb_mem_arbiter16;
    logic        clk = 1'b0;
    logic        reset, ins_rd_req, dat_rd_req, dat_wr_req;
    logic [15:0] ins_rd_addr, dat_rw_addr, dat_wr_data;
    logic [15:0] ins_rd_data, dat_rd_data, mem_addr, mem_wr_data, mem_rd_data;
    logic        ins_rd_rdy, dat_rd_rdy, dat_wr_rdy, err, mem_rd_en, mem_wr_en;
    logic [15:0] ram [0:65535];
    logic [15:0] rd_q;
    int checks = 0, errors = 0;
    always #5 clk = ~clk;
    mem_arbiter16 #(.STARVE_LIMIT(4)) dut (
        .clk(clk), .reset(reset),
        .ins_rd_addr(ins_rd_addr), .ins_rd_req(ins_rd_req), .ins_rd_data(ins_rd_data), .ins_rd_rdy(ins_rd_rdy),
        .dat_rw_addr(dat_rw_addr), .dat_wr_data(dat_wr_data), .dat_rd_req(dat_rd_req), .dat_wr_req(dat_wr_req),
        .dat_rd_data(dat_rd_data), .dat_rd_rdy(dat_rd_rdy), .dat_wr_rdy(dat_wr_rdy), .err(err),
        .mem_addr(mem_addr), .mem_wr_data(mem_wr_data), .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en),
        .mem_rd_data(mem_rd_data)
    );
    always @(posedge clk) begin
        if (mem_wr_en) ram[mem_addr] <= mem_wr_data;
        if (mem_rd_en) rd_q <= ram[mem_addr];
    end
    assign mem_rd_data = rd_q;
`ifdef MEM_ARBITER16_FAIRNESS_EN
    localparam bit FAIR = 1'b1;
`else
    localparam bit FAIR = 1'b0;
`endif
    localparam int LIMIT = 4;
    typedef struct {logic wr; logic [15:0] addr; logic [15:0] wdata;} req_t;
    req_t        slot[$];
    logic [15:0] shadow [0:65535];
    int          last_kind = 0, starve = 0;
    logic [15:0] last_data = 16'h0;
    logic        m_err = 1'b0;
    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask
    // kind: 0 none, 1 fetch, 2 load, 3 store
    task automatic cycle(input logic rst, input logic ins, input logic [15:0] iaddr,
                         input logic rd, input logic wr, input logic [15:0] daddr, input logic [15:0] wdat);
        req_t live, cand;
        bit has_live, has_cand, slot_granted, live_granted;
        int kind;
        logic [15:0] gaddr;
        @(negedge clk);
        reset = rst; ins_rd_req = ins; ins_rd_addr = iaddr;
        dat_rd_req = rd; dat_wr_req = wr; dat_rw_addr = daddr; dat_wr_data = wdat;
        #1;
        chk("ins_rdy", ins_rd_rdy, !rst && last_kind == 1);
        chk("drd_rdy", dat_rd_rdy, !rst && last_kind == 2);
        chk("dwr_rdy", dat_wr_rdy, !rst && last_kind == 3);
        if (!rst && last_kind == 1) chk("ins_data", ins_rd_data, last_data);
        if (!rst && last_kind == 2) chk("drd_data", dat_rd_data, last_data);
        chk("err", err, m_err);
        live = '{wr, daddr, wdat};
        has_live = rd || wr;
        has_cand = slot.size() > 0 || has_live;
        cand = slot.size() > 0 ? slot[0] : live;
        kind = 0;
        gaddr = 16'h0;
        if (!rst) begin
            if (ins && (!has_cand || (FAIR && starve == LIMIT))) begin
                kind = 1;
                gaddr = iaddr;
            end else if (has_cand) begin
                kind = cand.wr ? 3 : 2;
                gaddr = cand.addr;
            end
        end
        chk("mem_rd_en", mem_rd_en, kind == 1 || kind == 2);
        chk("mem_wr_en", mem_wr_en, kind == 3);
        chk("mem_addr", mem_addr, gaddr);
        if (kind == 3) chk("mem_wr_data", mem_wr_data, cand.wdata);
        if (rst) begin
            slot.delete();
            last_kind = 0;
            starve = 0;
            m_err = 1'b0;
        end else begin
            if (kind == 1 || kind == 2) last_data = shadow[gaddr];
            if (kind == 3) shadow[gaddr] = cand.wdata;
            slot_granted = kind >= 2 && slot.size() > 0;
            live_granted = kind >= 2 && slot.size() == 0;
            if (slot_granted) void'(slot.pop_front());
            if (has_live && !live_granted) begin
                if (slot.size() == 0) slot.push_back(live);
                else m_err = 1'b1;
            end
            if (rd && wr) m_err = 1'b1;
            starve = (!ins || kind == 1) ? 0 : starve + 1;
            last_kind = kind;
        end
    endtask
    initial begin
        for (int i = 0; i < 65536; i++) begin
            ram[i] = i < 4 ? 16'h1000 + 16'(i) : 16'(i * 7 + 3);
            shadow[i] = ram[i];
        end
        rd_q = 16'h0;
        reset = 1'b1; ins_rd_req = 1'b0; ins_rd_addr = 16'h0;
        dat_rd_req = 1'b0; dat_wr_req = 1'b0; dat_rw_addr = 16'h0; dat_wr_data = 16'h0;
        cycle(1, 1, 16'h0, 0, 0, 16'h0, 16'h0);
        cycle(1, 1, 16'h0, 0, 0, 16'h0, 16'h0);
        for (int a = 0; a < 4; a++) cycle(0, 1, 16'(a), 0, 0, 16'h0, 16'h0);
        cycle(0, 1, 16'h4, 0, 1, 16'h0040, 16'hBEEF);
        cycle(0, 1, 16'h5, 1, 0, 16'h0040, 16'h0);
        cycle(0, 1, 16'h6, 0, 0, 16'h0, 16'h0);
        cycle(0, 0, 16'h0, 0, 0, 16'h0, 16'h0);
        cycle(0, 0, 16'h0, 1, 1, 16'h0010, 16'h1234);
        cycle(0, 0, 16'h0, 0, 0, 16'h0, 16'h0);
        cycle(0, 0, 16'h0, 1, 0, 16'h0010, 16'h0);
        cycle(0, 1, 16'h7, 0, 0, 16'h0, 16'h0);
        cycle(0, 0, 16'h0, 0, 0, 16'h0, 16'h0);
        cycle(1, 0, 16'h0, 0, 0, 16'h0, 16'h0);
        for (int k = 0; k < 10; k++) cycle(0, 1, 16'h100 + 16'(k), 1, 0, 16'h20 + 16'(k), 16'h0);
        for (int k = 0; k < 3; k++) cycle(0, 0, 16'h0, 0, 0, 16'h0, 16'h0);
        cycle(1, 0, 16'h0, 0, 0, 16'h0, 16'h0);
        cycle(0, 0, 16'h0, 1, 0, 16'h0030, 16'h0);
        cycle(1, 1, 16'h0, 0, 0, 16'h0, 16'h0);
        cycle(0, 1, 16'h0, 0, 0, 16'h0, 16'h0);
        cycle(0, 1, 16'h1, 0, 0, 16'h0, 16'h0);
        for (int k = 0; k < 400; k++) begin
            int x;
            x = int'($urandom % 16);
            cycle($urandom % 60 == 0, $urandom % 4 != 0, 16'($urandom % 64),
                  x < 3 || x == 15, (x >= 3 && x < 6) || x == 15,
                  16'($urandom % 32), 16'($urandom));
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
